// File: rtl/ed25519_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ed25519_pkg
// Description : Shared constants and types for the SHA-512 / Ed25519 datapath
// Revision    : 1.0 - initial release
// ============================================================================
package ed25519_pkg;

   localparam int SHA512_DIGEST_BYTES = 64;
   localparam int SHA512_DIGEST_BITS  = 512;

   typedef logic [SHA512_DIGEST_BITS-1:0] sha512_digest_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/sha512_digest_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sha512_digest_streamer
// Description : Captures a SHA-512 digest on the rising edge of end_sha512
//               and streams it out little-endian over valid/ready, with
//               back-to-back reload, sticky overrun and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sha512_digest_streamer
   import ed25519_pkg::*;
#(
   parameter int DIGEST_BYTES = SHA512_DIGEST_BYTES,
   parameter int BEAT_BYTES   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      end_sha512,
   input  logic [8*DIGEST_BYTES-1:0] hash,
   input  logic                      flush,
   input  logic                      clr_overrun,
   input  logic                      tx_ready,
   output logic                      tx_valid,
   output logic [8*BEAT_BYTES-1:0]   tx_data,
   output logic                      tx_last,
   output logic                      busy,
   output logic                      overrun
);

   localparam int c_NUM_BEATS = DIGEST_BYTES / BEAT_BYTES;
   localparam int c_CNT_W     = (c_NUM_BEATS > 1) ? $clog2(c_NUM_BEATS) : 1;
   localparam int c_BEAT_BITS = 8 * BEAT_BYTES;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NUM_BEATS - 1);
   localparam logic c_ONE_BEAT = (c_NUM_BEATS == 1);

   stream_state_t                  r_state, w_state_nxt;
   logic [8*DIGEST_BYTES-1:0]      r_shift, w_shift_nxt;
   logic [c_CNT_W-1:0]             r_cnt, w_cnt_nxt;
   logic                           r_end_q;
   logic                           w_valid_nxt, w_last_nxt, w_busy_nxt, w_ovr_nxt;
   logic                           w_cap, w_accept, w_last_acc;
   logic [c_CNT_W-1:0]             w_cnt_inc;

   // Rising-edge capture: a held level loads only once
   assign w_cap      = end_sha512 & ~r_end_q;
   assign w_accept   = tx_valid & tx_ready;
   assign w_last_acc = w_accept & (r_cnt == c_LAST);
   assign w_cnt_inc  = r_cnt + c_CNT_W'(1);

   // Lowest beat of the shift register is always the beat on the wire
   assign tx_data = r_shift[c_BEAT_BITS-1:0];

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_end_q  <= 1'b0;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_cnt    <= w_cnt_nxt;
         r_end_q  <= end_sha512;
         tx_valid <= w_valid_nxt;
         tx_last  <= w_last_nxt;
         busy     <= w_busy_nxt;
         overrun  <= w_ovr_nxt;
      end
   end

   // Next-state logic: flush beats accept and capture; set beats clear
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = tx_valid;
      w_last_nxt  = tx_last;
      w_busy_nxt  = busy;
      w_ovr_nxt   = overrun & ~clr_overrun;

      if (flush) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_valid_nxt = 1'b0;
         w_last_nxt  = 1'b0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cap) begin
                  w_state_nxt = SEND;
                  w_shift_nxt = hash;
                  w_cnt_nxt   = '0;
                  w_valid_nxt = 1'b1;
                  w_last_nxt  = c_ONE_BEAT;
                  w_busy_nxt  = 1'b1;
               end
            end
            SEND: begin
               if (w_last_acc) begin
                  if (w_cap) begin
                     // Seamless reload: next beat is beat 0 of the new digest
                     w_shift_nxt = hash;
                     w_cnt_nxt   = '0;
                     w_last_nxt  = c_ONE_BEAT;
                  end else begin
                     w_state_nxt = IDLE;
                     w_shift_nxt = r_shift >> c_BEAT_BITS;
                     w_cnt_nxt   = '0;
                     w_valid_nxt = 1'b0;
                     w_last_nxt  = 1'b0;
                     w_busy_nxt  = 1'b0;
                  end
               end else begin
                  if (w_accept) begin
                     w_shift_nxt = r_shift >> c_BEAT_BITS;
                     w_cnt_nxt   = w_cnt_inc;
                     w_last_nxt  = (w_cnt_inc == c_LAST);
                  end
                  if (w_cap) begin
                     w_ovr_nxt = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sha512_digest_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha512_digest_streamer
// Description : Directed self-checking bench for sha512_digest_streamer with
//               one 1-byte-beat instance and one 8-byte-beat instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha512_digest_streamer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic         end1 = 1'b0, flush1 = 1'b0, clr1 = 1'b0, rdy1 = 1'b0;
   logic [511:0] hash1 = '0;
   logic         valid1, last1, busy1, ovr1;
   logic [7:0]   data1;

   logic         end8 = 1'b0, flush8 = 1'b0, clr8 = 1'b0, rdy8 = 1'b0;
   logic [511:0] hash8 = '0;
   logic         valid8, last8, busy8, ovr8;
   logic [63:0]  data8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sha512_digest_streamer #(.DIGEST_BYTES(64), .BEAT_BYTES(1)) dut1 (
      .clk(clk), .rst(rst), .end_sha512(end1), .hash(hash1), .flush(flush1),
      .clr_overrun(clr1), .tx_ready(rdy1), .tx_valid(valid1), .tx_data(data1),
      .tx_last(last1), .busy(busy1), .overrun(ovr1)
   );

   sha512_digest_streamer #(.DIGEST_BYTES(64), .BEAT_BYTES(8)) dut8 (
      .clk(clk), .rst(rst), .end_sha512(end8), .hash(hash8), .flush(flush8),
      .clr_overrun(clr8), .tx_ready(rdy8), .tx_valid(valid8), .tx_data(data8),
      .tx_last(last8), .busy(busy8), .overrun(ovr8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance one clock; inputs changed afterwards are seen at the next edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Digest whose byte i equals base+i
   function automatic logic [511:0] pat(input logic [7:0] base);
      logic [511:0] r;
      for (int i = 0; i < 64; i++) r[8*i +: 8] = base + 8'(i);
      return r;
   endfunction

   // Expected 8-byte beat k of pat(0)
   function automatic logic [63:0] word8(input int k);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8*k + j);
      return w;
   endfunction

   task automatic pulse1(input logic [511:0] h);
      hash1 = h;
      end1  = 1'b1;
      tick();
      end1  = 1'b0;
   endtask

   // Run dut1 until idle, bounded
   task automatic drain1();
      for (int c = 0; c < 200 && valid1; c++) tick();
      check("drain1_idle", {63'd0, valid1}, 64'd0);
   endtask

   logic [63:0] first8, last8w;
   logic [7:0]  rp [4];
   int k, beats;

   initial begin
      rp[0] = 1'b1; rp[1] = 1'b0; rp[2] = 1'b0; rp[3] = 1'b1;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_valid", {63'd0, valid1}, 64'd0);
      check("rst_data",  {56'd0, data1}, 64'd0);
      check("rst_busy",  {63'd0, busy1}, 64'd0);
      rst = 1'b0;
      tick();
      check("idle_valid", {63'd0, valid1}, 64'd0);
      check("idle_last",  {63'd0, last1}, 64'd0);
      check("idle_ovr",   {63'd0, ovr1}, 64'd0);
      check("idle_data8", data8, 64'd0);

      // ---------------- 1-byte beats, full throughput ----------------
      rdy1 = 1'b1;
      pulse1(pat(8'h00));
      check("t1_first_valid", {63'd0, valid1}, 64'd1);
      for (int i = 0; i < 64; i++) begin
         check("t1_data",  {56'd0, data1}, 64'(i));
         check("t1_last",  {63'd0, last1}, 64'(i == 63));
         check("t1_valid", {63'd0, valid1}, 64'd1);
         tick();
      end
      check("t1_end_valid", {63'd0, valid1}, 64'd0);
      check("t1_end_busy",  {63'd0, busy1}, 64'd0);

      // ---------------- 8-byte beats with stalls ----------------
      hash8 = pat(8'h00);
      end8  = 1'b1;
      tick();
      end8  = 1'b0;
      k = 0;
      for (int c = 0; c < 100 && k < 8; c++) begin
         rdy8 = rp[c % 4][0];
         check("t2_valid", {63'd0, valid8}, 64'd1);
         check("t2_data",  data8, word8(k));
         check("t2_last",  {63'd0, last8}, 64'(k == 7));
         if (k == 0) first8 = data8;
         if (k == 7) last8w = data8;
         tick();
         if (rdy8) k++;
      end
      rdy8 = 1'b0;
      check("t2_beats",   64'(k), 64'd8);
      check("t2_beat0",   first8, 64'h0706050403020100);
      check("t2_beat7",   last8w, 64'h3F3E3D3C3B3A3938);
      check("t2_idle",    {63'd0, valid8}, 64'd0);

      // ---------------- held level captures once ----------------
      hash1 = pat(8'h00);
      end1  = 1'b1;
      beats = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (valid1) begin
            check("t3_data", {56'd0, data1}, 64'(beats));
            beats++;
         end
      end
      end1 = 1'b0;
      tick();
      check("t3_beats", 64'(beats), 64'd64);
      check("t3_ovr",   {63'd0, ovr1}, 64'd0);
      check("t3_idle",  {63'd0, valid1}, 64'd0);

      // ---------------- overrun during transfer ----------------
      pulse1(pat(8'h00));
      for (int i = 0; i < 64; i++) begin
         if (i == 10) begin end1 = 1'b1; hash1 = '1; end
         if (i == 11) end1 = 1'b0;
         check("t4_data", {56'd0, data1}, 64'(i));
         tick();
      end
      check("t4_ovr",  {63'd0, ovr1}, 64'd1);
      check("t4_idle", {63'd0, valid1}, 64'd0);
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      check("t4_clr", {63'd0, ovr1}, 64'd0);
      pulse1(pat(8'h00));
      for (int i = 0; i < 5; i++) tick();
      end1 = 1'b1; clr1 = 1'b1;
      tick();
      end1 = 1'b0; clr1 = 1'b0;
      check("t4_set_wins", {63'd0, ovr1}, 64'd1);
      drain1();
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      check("t4_clr2", {63'd0, ovr1}, 64'd0);

      // ---------------- back-to-back reload on last beat ----------------
      pulse1(pat(8'h00));
      for (int i = 0; i < 63; i++) tick();
      check("t5_at_last", {56'd0, data1}, 64'h3F);
      hash1 = pat(8'h40);
      end1  = 1'b1;
      tick();
      end1  = 1'b0;
      for (int j = 0; j < 64; j++) begin
         check("t5_valid", {63'd0, valid1}, 64'd1);
         check("t5_data",  {56'd0, data1}, 64'(8'h40 + j));
         tick();
      end
      check("t5_ovr",  {63'd0, ovr1}, 64'd0);
      check("t5_idle", {63'd0, valid1}, 64'd0);

      // ---------------- flush at beat 20, with a coincident capture ----------------
      pulse1(pat(8'h00));
      for (int i = 0; i < 20; i++) tick();
      check("t6_at20", {56'd0, data1}, 64'd20);
      flush1 = 1'b1; end1 = 1'b1; hash1 = pat(8'h80);
      tick();
      flush1 = 1'b0; end1 = 1'b0;
      check("t6_valid", {63'd0, valid1}, 64'd0);
      check("t6_busy",  {63'd0, busy1}, 64'd0);
      check("t6_ovr",   {63'd0, ovr1}, 64'd0);
      tick();
      check("t6_no_cap", {63'd0, valid1}, 64'd0);
      pulse1(pat(8'h00));
      check("t6_restart_valid", {63'd0, valid1}, 64'd1);
      check("t6_restart_data",  {56'd0, data1}, 64'd0);
      drain1();

      // ---------------- async reset at beat 30 ----------------
      pulse1(pat(8'h00));
      for (int i = 0; i < 30; i++) tick();
      check("t7_at30", {56'd0, data1}, 64'd30);
      #2 rst = 1'b1;
      #1;
      check("t7_async_valid", {63'd0, valid1}, 64'd0);
      check("t7_async_busy",  {63'd0, busy1}, 64'd0);
      check("t7_async_data",  {56'd0, data1}, 64'd0);
      end1 = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("t7_recap_valid", {63'd0, valid1}, 64'd1);
      check("t7_recap_data",  {56'd0, data1}, 64'd0);
      end1 = 1'b0;
      drain1();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
